// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures the high time and period of a PWM waveform in clk
// cycles, rising edge to rising edge, and flags a PWM that has stopped
// toggling. The input may be asynchronous to clk; only the synchronized copy
// is used by the measurement logic.
module pwm_duty_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             level
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  // per_run value one below all-ones: the next increment would saturate.
  localparam logic [CNT_W-1:0] SAT_LIM = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   sat;

  state_t                 state;
  state_t                 state_n;

  logic [CNT_W-1:0]       per_run;
  logic [CNT_W-1:0]       per_run_n;
  logic [CNT_W-1:0]       hi_run;
  logic [CNT_W-1:0]       hi_run_n;
  logic [CNT_W-1:0]       high_cnt_n;
  logic [CNT_W-1:0]       period_cnt_n;
  logic                   meas_valid_n;
  logic                   stuck_n;

  // Synchronizer chain for pwm_in plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      // NOTE: flops are written with <= so every stage samples the value its
      // predecessor held before this edge; '=' would collapse the chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign level = s;
  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  // A run that has counted up to SAT_LIM without a closing rise is stuck.
  assign sat   = (per_run == SAT_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; dropping ena overrides everything, including a rise.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for unlisted conditions.
    state_n = state;
    if (!ena) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: state_n = ARM;
        ARM:  if (rise) state_n = HIGH;
        HIGH: begin
          if (sat)       state_n = ARM;
          else if (fall) state_n = LOW;
        end
        LOW: begin
          // A closing rise wins over saturation: the period is still valid.
          if (rise)     state_n = HIGH;
          else if (sat) state_n = ARM;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Run counters, result latch, measurement pulse and stuck flag.
  always_comb begin
    per_run_n    = per_run;
    hi_run_n     = hi_run;
    high_cnt_n   = high_cnt;
    period_cnt_n = period_cnt;
    meas_valid_n = 1'b0;
    stuck_n      = stuck;
    if (!ena) begin
      per_run_n = '0;
      hi_run_n  = '0;
      stuck_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          per_run_n = '0;
          hi_run_n  = '0;
          stuck_n   = 1'b0;
        end
        ARM: begin
          if (rise) begin
            per_run_n = ONE;
            hi_run_n  = ONE;
            stuck_n   = 1'b0;
          end else begin
            per_run_n = '0;
            hi_run_n  = '0;
          end
        end
        HIGH: begin
          if (sat) begin
            per_run_n = '0;
            hi_run_n  = '0;
            stuck_n   = 1'b1;
          end else begin
            per_run_n = per_run + ONE;
            // The fall cycle has s=0, so it counts toward the period only.
            if (s) hi_run_n = hi_run + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            period_cnt_n = per_run;
            high_cnt_n   = hi_run;
            meas_valid_n = 1'b1;
            per_run_n    = ONE;
            hi_run_n     = ONE;
          end else if (sat) begin
            per_run_n = '0;
            hi_run_n  = '0;
            stuck_n   = 1'b1;
          end else begin
            per_run_n = per_run + ONE;
          end
        end
        default: begin
          per_run_n = '0;
          hi_run_n  = '0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_run    <= '0;
      hi_run     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      per_run    <= per_run_n;
      hi_run     <= hi_run_n;
      high_cnt   <= high_cnt_n;
      period_cnt <= period_cnt_n;
      meas_valid <= meas_valid_n;
      stuck      <= stuck_n;
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter: directed PWM waveforms with hand-computed
// periods, high times and pulse cycles, plus corner-case sequences for
// saturation, enable drop and asynchronous reset.
module tb_pwm_duty_meter;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TAIL        = 4;
  localparam int NO_SWITCH   = 32'h7fff_ffff;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             level;

  pwm_duty_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .stuck     (stuck),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Posedge counter used to timestamp observations.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int per;
    int hi;
  } meas_t;

  typedef struct {
    int p;
    int h;
    int n;
    int exp_cnt;
    int exp_per;
    int exp_hi;
  } vec_t;

  meas_t            mq[$];
  int               hold_err       = 0;
  int               stuck_rise_cyc = -1;
  int               stuck_fall_cyc = -1;
  logic [CNT_W-1:0] prev_per       = '0;
  logic [CNT_W-1:0] prev_hi        = '0;
  logic             prev_stuck     = 1'b0;

  int n_cmp     = 0;
  int n_bad     = 0;
  int drv_start = 0;
  int t0        = 0;

  // Monitor: logs every meas_valid pulse, stuck transitions, and any result
  // change that happens without a pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (meas_valid === 1'b1)
        mq.push_back(meas_t'{cyc, int'(period_cnt), int'(high_cnt)});
      else if (period_cnt !== prev_per || high_cnt !== prev_hi)
        hold_err <= hold_err + 1;
      if (stuck === 1'b1 && prev_stuck === 1'b0) stuck_rise_cyc <= cyc;
      if (stuck === 1'b0 && prev_stuck === 1'b1) stuck_fall_cyc <= cyc;
    end
    prev_per   <= period_cnt;
    prev_hi    <= high_cnt;
    prev_stuck <= stuck;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drop ena to flush to IDLE with pwm low, then re-enable into ARM.
  task automatic arm();
    @(negedge clk);
    ena    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    mq.delete();
    stuck_rise_cyc = -1;
    stuck_fall_cyc = -1;
  endtask

  // Clock-synchronous PWM: pwm = (c % p) < h, with h switching from h_a to
  // h_b at c = sw, ena low for lo_from <= c < lo_to, rise at c = t_end, then
  // held high for TAIL cycles so no further rise occurs.
  task automatic drive_wave(input int t_end, input int p, input int h_a, input int h_b,
                            input int sw, input int lo_from, input int lo_to);
    for (int c = 0; c <= t_end + TAIL; c++) begin
      @(negedge clk);
      if (c == 0) drv_start = cyc;
      if (c <= t_end) pwm_in = ((c % p) < ((c < sw) ? h_a : h_b));
      else            pwm_in = 1'b1;
      ena = !(c >= lo_from && c < lo_to);
    end
    #1;
  endtask

  // Compare logged pulse idx against expected cycle offset from drv_start.
  task automatic check_pulse(input string tag, input int idx, input int off,
                             input int per, input int hi);
    if (idx < mq.size()) begin
      check($sformatf("%s#%0d cycle", tag, idx), mq[idx].cyc, drv_start + off);
      check($sformatf("%s#%0d period_cnt", tag, idx), mq[idx].per, per);
      check($sformatf("%s#%0d high_cnt", tag, idx), mq[idx].hi, hi);
    end
  endtask

  // n pulses of per/hi, the i-th (from 0) closing at rise (i+1)*p.
  task automatic check_pulses(input string tag, input int n, input int p,
                              input int per, input int hi);
    check($sformatf("%s pulse count", tag), mq.size(), n);
    for (int i = 0; i < n; i++) check_pulse(tag, i, (i + 1) * p + 3, per, hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{100, 25, 3, 3, 100, 25};
    vecs[1] = '{2, 1, 6, 6, 2, 1};
    vecs[2] = '{10, 3, 4, 4, 10, 3};
    vecs[3] = '{3, 2, 4, 4, 3, 2};
    vecs[4] = '{7, 1, 3, 3, 7, 1};
    vecs[5] = '{50, 49, 2, 2, 50, 49};
    vecs[6] = '{254, 100, 1, 1, 254, 100};  // longest measurable period
    vecs[7] = '{255, 100, 2, 0, 0, 0};      // saturates every period

    rst_n  = 1'b0;
    ena    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset high_cnt", high_cnt, 0);
    check("reset period_cnt", period_cnt, 0);
    check("reset meas_valid", meas_valid, 0);
    check("reset stuck", stuck, 0);
    check("reset level", level, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven stable waveforms.
    for (int v = 0; v < 8; v++) begin
      arm();
      drive_wave(vecs[v].n * vecs[v].p, vecs[v].p, vecs[v].h, vecs[v].h,
                 NO_SWITCH, -1, -1);
      check_pulses($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].p,
                   vecs[v].exp_per, vecs[v].exp_hi);
    end

    // Duty change 25 -> 75 at the c=200 period boundary.
    arm();
    drive_wave(300, 100, 25, 75, 200, -1, -1);
    check("duty pulse count", mq.size(), 3);
    check_pulse("duty", 0, 103, 100, 25);
    check_pulse("duty", 1, 203, 100, 25);
    check_pulse("duty", 2, 303, 100, 75);

    // ena low for 30 cycles mid high phase: partial period discarded,
    // re-arm on rise at 200, first new measurement at rise 300.
    arm();
    drive_wave(300, 100, 25, 25, NO_SWITCH, 110, 140);
    check("ena pulse count", mq.size(), 2);
    check_pulse("ena", 0, 103, 100, 25);
    check_pulse("ena", 1, 303, 100, 25);
    check("ena stuck", stuck, 0);

    // ena dropped exactly on the cycle the rise at c=10 is evaluated.
    arm();
    drive_wave(30, 10, 3, 3, NO_SWITCH, 12, 13);
    check("ena-vs-rise pulse count", mq.size(), 1);
    check_pulse("ena-vs-rise", 0, 33, 10, 3);

    // Held high after a rise: stuck when per_run would reach 255.
    arm();
    @(negedge clk);
    pwm_in = 1'b1;
    t0     = cyc;
    repeat (256) @(negedge clk);
    #1;
    check("stuck-hi before MAX", stuck, 0);
    @(negedge clk);
    #1;
    check("stuck-hi at MAX", stuck, 1);
    check("stuck-hi level", level, 1);
    check("stuck-hi rise cycle", stuck_rise_cyc, t0 + 257);
    check("stuck-hi pulse count", mq.size(), 0);
    repeat (7) begin
      @(negedge clk);
      pwm_in = 1'b0;
    end
    #1;
    check("stuck-hi held", stuck, 1);
    drive_wave(10, 10, 3, 3, NO_SWITCH, -1, -1);
    check("stuck-hi clear cycle", stuck_fall_cyc, drv_start + 3);
    check_pulses("resume-hi", 1, 10, 10, 3);

    // Held low after a short high: same saturation point, level=0.
    arm();
    @(negedge clk);
    pwm_in = 1'b1;
    t0     = cyc;
    repeat (3) @(negedge clk);
    pwm_in = 1'b0;
    repeat (253) @(negedge clk);
    #1;
    check("stuck-lo before MAX", stuck, 0);
    @(negedge clk);
    #1;
    check("stuck-lo at MAX", stuck, 1);
    check("stuck-lo level", level, 0);
    check("stuck-lo rise cycle", stuck_rise_cyc, t0 + 257);
    check("stuck-lo pulse count", mq.size(), 0);
    drive_wave(10, 10, 3, 3, NO_SWITCH, -1, -1);
    check("stuck-lo clear cycle", stuck_fall_cyc, drv_start + 3);
    check_pulses("resume-lo", 1, 10, 10, 3);

    // Asynchronous reset in the middle of a high phase, released while low.
    arm();
    for (int c = 0; c <= 300 + TAIL; c++) begin
      @(negedge clk);
      if (c == 0) drv_start = cyc;
      pwm_in = (c <= 300) ? ((c % 100) < 25) : 1'b1;
      if (c == 110) begin
        #1;
        check("pre-reset level", level, 1);
        check("pre-reset period_cnt", period_cnt, 100);
        check("pre-reset high_cnt", high_cnt, 25);
        #2 rst_n = 1'b0;
        #1;
        check("async reset high_cnt", high_cnt, 0);
        check("async reset period_cnt", period_cnt, 0);
        check("async reset meas_valid", meas_valid, 0);
        check("async reset stuck", stuck, 0);
        check("async reset level", level, 0);
        mq.delete();
      end
      if (c == 120) begin
        #1;
        check("in-reset level", level, 0);
      end
      if (c == 130) rst_n = 1'b1;
    end
    #1;
    check("post-reset pulse count", mq.size(), 1);
    check_pulse("post-reset", 0, 303, 100, 25);

    check("results changed without meas_valid", hold_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Downstream companion to the PWM generator: it samples a PWM waveform and measures the high time and the period of each complete cycle, in clock cycles.
- It feeds the duty-cycle loopback / readback path, so the generator's output can be checked on-chip and reported through the IOs.
- It also flags a PWM that has stopped toggling (0 % or 100 % duty, or a dead source).

Parameters:
- CNT_W, 16, width of the measurement counters and outputs; saturation value MAX = 2**CNT_W-1.
- SYNC_STAGES, 2, number of synchronizer flops on pwm_in; legal values are 2 or more.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  measurement enable; low forces IDLE.
- pwm_in  in  1  PWM under measurement; may be asynchronous to clk.
- high_cnt  out  CNT_W  high time of the last complete period, in clk cycles.
- period_cnt  out  CNT_W  length of the last complete period, rising edge to rising edge.
- meas_valid  out  1  one-cycle pulse when high_cnt/period_cnt update.
- stuck  out  1  no rising edge for MAX cycles.
- level  out  1  current synchronized pwm_in level (meaningful while stuck=1).

Behaviour:
- Reset:
  - While rst_n=0, all flops clear immediately and asynchronously.
  - high_cnt=0, period_cnt=0, meas_valid=0, stuck=0, level=0, state=IDLE.
- Synchronizer and edge detect:
  - pwm_in passes through SYNC_STAGES flops, giving s; s also drives level.
  - One further flop holds s_d.
  - rise = s & ~s_d, fall = ~s & s_d.
  - No other logic samples pwm_in directly.
- Run counters: per_run and hi_run, both CNT_W wide.
- States: IDLE, ARM, HIGH, LOW.
  - IDLE: per_run=hi_run=0, stuck cleared. Go to ARM when ena=1.
  - ARM: waits for the first rise. On rise: per_run=1, hi_run=1, go to HIGH. No measurement is produced from ARM.
  - HIGH:
    - Every cycle, per_run increments and hi_run increments while s=1.
    - On fall: go to LOW (per_run increments, hi_run does not).
  - LOW:
    - per_run increments.
    - On rise: latch period_cnt=per_run and high_cnt=hi_run, pulse meas_valid, reload per_run=1 and hi_run=1, go to HIGH.
- Count semantics:
  - For a clk-synchronous PWM with period P and high time H (in clocks), every measurement after arming gives period_cnt=P and high_cnt=H exactly.
  - Minimum measurable waveform: P=2, H=1.
- Latency:
  - If pwm_in is first sampled high at clock edge k, meas_valid is high after edge k+SYNC_STAGES and low again after edge k+SYNC_STAGES+1.
  - high_cnt and period_cnt change only in that same cycle and hold otherwise.
- Saturation / stuck:
  - In HIGH or LOW, if per_run reaches MAX: set stuck=1, go to ARM, discard the run, no meas_valid.
  - stuck stays 1 until the next rise, then clears on that cycle.
  - The first valid measurement after stuck requires one full period (behaviour as from ARM).
- ena=0 in any state:
  - Next cycle goes to IDLE; a partial period is discarded.
  - meas_valid=0, stuck=0.
  - high_cnt/period_cnt hold their last values.
- Simultaneous rise and ena deassert: ena wins; no measurement.
- Counter arithmetic is unsigned and never wraps; hi_run ≤ per_run always.

Test Plan:
- Reset: assert rst_n=0 mid-run with s=1 in HIGH → all outputs 0 with no clock edge; release → IDLE, then ARM, no meas_valid until two rises have been seen.
- Stable PWM P=100, H=25, SYNC_STAGES=2 → first rise only arms; from the second rise, meas_valid pulses every 100 cycles with period_cnt=100, high_cnt=25; pulse lands 2 edges after the pwm_in rise sample.
- Duty change H 25→75 at a period boundary, P=100 → next measurement is period_cnt=100, high_cnt=75; there is no intermediate value.
- CNT_W=8, pwm_in held high after a rise → stuck=1, level=1 exactly when per_run hits 255, no meas_valid. Then resume P=10, H=3 → stuck clears on the first rise; next meas_valid gives 10/3. Repeat with the input held low → level=0.
- ena=0 for 30 cycles in the middle of the high phase of P=100, H=25 → no meas_valid, outputs hold 100/25; after ena=1, the first new measurement comes one full period after the next rise.
- Minimum waveform P=2, H=1 (clk/2 toggle) → meas_valid every 2 cycles with period_cnt=2, high_cnt=1.
